// File: rtl/sal_ref_ctrl.sv
// Refresh scheduler: interval timer, postponed-credit counter and an
// all-bank REF handshake (request every bank, wait for all grants, issue REF).
module sal_ref_ctrl #(
   parameter int BK_CNT   = 16,
   parameter int MAX_PEND = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       cfg_ref_en_i,
   input  logic [15:0]                cfg_trefi_i,
   input  logic [9:0]                 cfg_trfc_i,
   output logic [BK_CNT-1:0]          ref_req_o,
   input  logic [BK_CNT-1:0]          ref_gnt_i,
   output logic                       ref_cmd_o,
   output logic                       ref_busy_o,
   output logic [$clog2(MAX_PEND):0]  pend_cnt_o,
   output logic                       ref_ovf_o
);

   localparam int PW = $clog2(MAX_PEND) + 1;
   localparam logic [PW-1:0] PEND_MAX = PW'(MAX_PEND);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      REFRESH = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [15:0]       ivl_q, ivl_d;
   logic              run_q, run_d;
   logic [9:0]        rfc_q, rfc_d;
   logic [PW-1:0]     pend_q, pend_d;
   logic              ovf_q, ovf_d;
   logic [BK_CNT-1:0] mask_q, mask_d;
   logic [BK_CNT-1:0] req_q, req_d;
   logic              cmd_q, cmd_d;
   logic              busy_q, busy_d;

   logic [15:0]       ivl_rld;
   logic [15:0]       ivl_cur;
   logic [9:0]        rfc_rld;
   logic [BK_CNT-1:0] gnt_all;
   logic              tick;
   logic              done;

   assign ivl_rld = (cfg_trefi_i == 16'd0) ? 16'd0 : cfg_trefi_i - 16'd1;
   assign rfc_rld = (cfg_trfc_i == 10'd0) ? 10'd0 : cfg_trfc_i - 10'd1;

   // run_q low means the timer sits at its reload value; this avoids a
   // config-dependent reset value and restarts the interval after a pause.
   assign ivl_cur = run_q ? ivl_q : ivl_rld;
   assign tick    = cfg_ref_en_i && (ivl_cur == 16'd0);
   assign done    = (state_q == REFRESH) && (rfc_q == 10'd0);
   assign gnt_all = mask_q | ref_gnt_i;

   always_comb begin
      run_d = cfg_ref_en_i;
      ivl_d = ivl_q;
      if (!cfg_ref_en_i) begin
         ivl_d = ivl_rld;
      end else if (tick) begin
         ivl_d = ivl_rld;
      end else begin
         ivl_d = ivl_cur - 16'd1;
      end
   end

   always_comb begin
      pend_d = pend_q;
      ovf_d  = ovf_q;
      if (tick && !done) begin
         if (pend_q == PEND_MAX) begin
            ovf_d = 1'b1;
         end else begin
            pend_d = pend_q + 1'b1;
         end
      end else if (done && !tick) begin
         pend_d = pend_q - 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      mask_d  = mask_q;
      rfc_d   = rfc_q;
      cmd_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if ((pend_q != '0) && cfg_ref_en_i) begin
               state_d = REQ;
               mask_d  = '0;
            end
         end
         REQ: begin
            mask_d = gnt_all;
            if (&gnt_all) begin
               state_d = REFRESH;
               rfc_d   = rfc_rld;
               cmd_d   = 1'b1;
            end
         end
         REFRESH: begin
            if (done) begin
               state_d = IDLE;
            end else begin
               rfc_d = rfc_q - 10'd1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE);
      req_d  = {BK_CNT{busy_d}};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ivl_q   <= '0;
         run_q   <= 1'b0;
         rfc_q   <= '0;
         pend_q  <= '0;
         ovf_q   <= 1'b0;
         mask_q  <= '0;
         req_q   <= '0;
         cmd_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ivl_q   <= ivl_d;
         run_q   <= run_d;
         rfc_q   <= rfc_d;
         pend_q  <= pend_d;
         ovf_q   <= ovf_d;
         mask_q  <= mask_d;
         req_q   <= req_d;
         cmd_q   <= cmd_d;
         busy_q  <= busy_d;
      end
   end

   assign ref_req_o  = req_q;
   assign ref_cmd_o  = cmd_q;
   assign ref_busy_o = busy_q;
   assign pend_cnt_o = pend_q;
   assign ref_ovf_o  = ovf_q;

endmodule

// File: tb/tb_sal_ref_ctrl.sv
// Randomised bench for sal_ref_ctrl against a timestamp-based
// reference model of the refresh scheduler.
module tb_sal_ref_ctrl;

   localparam int BK   = 16;
   localparam int MAXP = 8;
   localparam int PW   = $clog2(MAXP) + 1;
   localparam logic [BK-1:0] ALL1 = '1;
   localparam logic [BK-1:0] ZERO = '0;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cfg_ref_en_i = 1'b0;
   logic [15:0]   cfg_trefi_i = 16'd100;
   logic [9:0]    cfg_trfc_i = 10'd20;
   logic [BK-1:0] ref_req_o;
   logic [BK-1:0] ref_gnt_i = '0;
   logic          ref_cmd_o;
   logic          ref_busy_o;
   logic [PW-1:0] pend_cnt_o;
   logic          ref_ovf_o;

   int n_vec = 0;
   int n_err = 0;

   // model: phase 0 idle, 1 collecting grants, 2 refreshing until m_end
   int            m_phase;
   int            m_cred;
   int            m_run;
   int            m_cyc;
   int            m_end;
   bit            m_ovf;
   bit            m_cmd;
   logic [BK-1:0] m_mask;

   sal_ref_ctrl #(.BK_CNT(BK), .MAX_PEND(MAXP)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .cfg_ref_en_i (cfg_ref_en_i),
      .cfg_trefi_i  (cfg_trefi_i),
      .cfg_trfc_i   (cfg_trfc_i),
      .ref_req_o    (ref_req_o),
      .ref_gnt_i    (ref_gnt_i),
      .ref_cmd_o    (ref_cmd_o),
      .ref_busy_o   (ref_busy_o),
      .pend_cnt_o   (pend_cnt_o),
      .ref_ovf_o    (ref_ovf_o)
   );

   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: sim time %0t exceeded, required finish", $time);
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)",
                  tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_phase = 0;
      m_cred  = 0;
      m_run   = 0;
      m_cyc   = 0;
      m_end   = 0;
      m_ovf   = 1'b0;
      m_cmd   = 1'b0;
      m_mask  = '0;
   endtask

   task automatic model_step();
      int  t;
      int  f;
      int  c0;
      bit  tk;
      bit  cp;
      t  = (cfg_trefi_i == 0) ? 1 : int'(cfg_trefi_i);
      f  = (cfg_trfc_i == 0) ? 1 : int'(cfg_trfc_i);
      m_cyc++;
      tk = 1'b0;
      if (cfg_ref_en_i) begin
         m_run++;
         tk = ((m_run % t) == 0);
      end else begin
         m_run = 0;
      end
      cp = (m_phase == 2) && (m_cyc == m_end);
      c0 = m_cred;
      if (tk && !cp) begin
         if (m_cred == MAXP) m_ovf = 1'b1;
         else m_cred++;
      end else if (cp && !tk) begin
         m_cred--;
      end
      m_cmd = 1'b0;
      if (m_phase == 0) begin
         if (c0 > 0 && cfg_ref_en_i) begin
            m_phase = 1;
            m_mask  = '0;
         end
      end else if (m_phase == 1) begin
         m_mask = m_mask | ref_gnt_i;
         if (m_mask == ALL1) begin
            m_phase = 2;
            m_end   = m_cyc + f;
            m_cmd   = 1'b1;
         end
      end else if (cp) begin
         m_phase = 0;
      end
   endtask

   task automatic check_outs();
      chk("ref_req", 32'(ref_req_o), 32'((m_phase != 0) ? ALL1 : ZERO));
      chk("ref_busy", 32'(ref_busy_o), 32'(m_phase != 0));
      chk("ref_cmd", 32'(ref_cmd_o), 32'(m_cmd));
      chk("pend_cnt", 32'(pend_cnt_o), 32'(m_cred));
      chk("ref_ovf", 32'(ref_ovf_o), 32'(m_ovf));
   endtask

   // called at a negedge; applies inputs for one rising edge
   task automatic cyc(input bit e, input logic [BK-1:0] g);
      cfg_ref_en_i = e;
      ref_gnt_i    = g;
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_outs();
   endtask

   task automatic do_reset(input int trefi, input int trfc);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_outs();
      cfg_ref_en_i = 1'b0;
      ref_gnt_i    = '0;
      cfg_trefi_i  = 16'(trefi);
      cfg_trfc_i   = 10'(trfc);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int            n;
      bit            e;
      logic [BK-1:0] g;

      model_reset();
      @(negedge clk);

      do_reset(100, 20);
      repeat (320) cyc(1'b1, ALL1);
      for (int i = 0; i < 200 && m_phase != 2; i++) cyc(1'b1, ALL1);
      chk("in_refresh", 32'(ref_busy_o), 32'd1);

      do_reset(100, 20);
      n = 0;
      for (int i = 1; i <= 110; i++) begin
         cyc(1'b1, ZERO);
         if (pend_cnt_o != 0) begin
            n = i;
            break;
         end
      end
      chk("first_tick", 32'(n), 32'd100);

      do_reset(50, 20);
      repeat (460) cyc(1'b1, ZERO);
      chk("ovf_pend", 32'(pend_cnt_o), 32'(MAXP));
      chk("ovf_flag", 32'(ref_ovf_o), 32'd1);
      repeat (500) cyc(1'b1, ALL1);

      do_reset(30, 5);
      n = 0;
      for (int k = 0; k < 60; k++) begin
         g = '0;
         if (k >= 40 && k - 40 < BK) g[k-40] = 1'b1;
         cyc(1'b1, g);
         if (ref_cmd_o) n++;
      end
      chk("stagger_cmds", 32'(n), 32'd1);

      do_reset(12, 10);
      repeat (120) cyc(1'b1, ALL1);
      chk("coin_pend", 32'(pend_cnt_o), 32'd1);
      chk("coin_ovf", 32'(ref_ovf_o), 32'd0);

      do_reset(40, 8);
      for (int i = 0; i < 100 && m_phase != 1; i++) cyc(1'b1, ZERO);
      repeat (5) cyc(1'b0, ZERO);
      n = 0;
      for (int i = 0; i < 1000; i++) begin
         cyc(1'b0, ALL1);
         if (ref_cmd_o) n++;
      end
      chk("endrop_cmds", 32'(n), 32'd1);
      chk("endrop_pend", 32'(pend_cnt_o), 32'd0);

      do_reset(0, 0);
      repeat (60) cyc(1'b1, BK'($urandom));

      for (int s = 0; s < 6; s++) begin
         do_reset(int'($urandom_range(1, 40)), int'($urandom_range(0, 15)));
         e = 1'b1;
         repeat (300) begin
            if ($urandom_range(0, 19) == 0) e = !e;
            g = BK'($urandom);
            if ($urandom_range(0, 2) == 0) g = ALL1;
            cyc(e, g);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
